// File: rtl/alu_pkg.sv
// Shared opcode constants, counter width and buffered entry layout for the
// ALU result stage.
package alu_pkg;

   localparam logic [2:0] OP_ADD   = 3'b000;
   localparam logic [2:0] OP_SUB   = 3'b001;
   localparam logic [2:0] OP_LOGIC = 3'b010;
   localparam logic [2:0] OP_MUL   = 3'b011;

   localparam int CNT_W_DEF = 8;

   typedef struct packed {
      logic [7:0] res;
      logic       zero;
      logic       carry;
      logic       err;
   } entry_t;

   // zero flag is derived here so every producer computes it the same way
   function automatic entry_t make_entry(
      input logic [7:0] res,
      input logic       carry,
      input logic       err
   );
      entry_t e;
      e.res   = res;
      e.zero  = (res == 8'h00);
      e.carry = carry;
      e.err   = err;
      return e;
   endfunction

endpackage

// File: rtl/alu_skid_fifo2.sv
// Two-entry valid/ready buffer of entry_t. All outputs come straight from
// registers, so push_ready never depends combinationally on pop_ready.
module alu_skid_fifo2
   import alu_pkg::*;
#(
   parameter int DEPTH = 2
)(
   input  logic   clk,
   input  logic   rst,
   input  logic   push_valid,
   output logic   push_ready,
   input  entry_t push_data,
   output logic   pop_valid,
   input  logic   pop_ready,
   output entry_t pop_data
);

   localparam logic [1:0] FULL_CNT = 2'(DEPTH);

   entry_t     mem_r [2];
   logic       wr_ptr_r;
   logic       rd_ptr_r;
   logic [1:0] count_r;
   logic       push_ready_r;
   logic       pop_valid_r;
   entry_t     head_r;

   logic       push_s;
   logic       pop_s;
   logic       wr_ptr_s;
   logic       rd_ptr_s;
   logic [1:0] count_s;
   entry_t     head_s;

   assign push_s = push_valid && push_ready_r;
   assign pop_s  = pop_valid_r && pop_ready;

   // next pointers, occupancy and the head entry as it will look after this edge
   always_comb begin
      wr_ptr_s = wr_ptr_r;
      rd_ptr_s = rd_ptr_r;
      count_s  = count_r;
      head_s   = '0;
      if (push_s) begin
         wr_ptr_s = wr_ptr_r ^ 1'b1;
      end else begin
         wr_ptr_s = wr_ptr_r;
      end
      if (pop_s) begin
         rd_ptr_s = rd_ptr_r ^ 1'b1;
      end else begin
         rd_ptr_s = rd_ptr_r;
      end
      case ({push_s, pop_s})
         2'b10:   count_s = count_r + 2'd1;
         2'b01:   count_s = count_r - 2'd1;
         default: count_s = count_r;
      endcase
      // a write landing on the new read slot bypasses the storage array
      if (count_s == 2'd0) begin
         head_s = '0;
      end else if (push_s && (wr_ptr_r == rd_ptr_s)) begin
         head_s = push_data;
      end else begin
         head_s = mem_r[rd_ptr_s];
      end
   end

   // storage, pointers and registered handshake/data outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_r[0]     <= '0;
         mem_r[1]     <= '0;
         wr_ptr_r     <= 1'b0;
         rd_ptr_r     <= 1'b0;
         count_r      <= 2'd0;
         push_ready_r <= 1'b1;
         pop_valid_r  <= 1'b0;
         head_r       <= '0;
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= push_data;
         end
         wr_ptr_r     <= wr_ptr_s;
         rd_ptr_r     <= rd_ptr_s;
         count_r      <= count_s;
         push_ready_r <= (count_s != FULL_CNT);
         pop_valid_r  <= (count_s != 2'd0);
         head_r       <= head_s;
      end
   end

   assign push_ready = push_ready_r;
   assign pop_valid  = pop_valid_r;
   assign pop_data   = head_r;

endmodule

// File: rtl/alu_result_stage.sv
// Result stage for the ALU lines: opcode select, push-time flags, a 2-entry
// skid buffer and debug counters (wrapping op count, saturating error count).
module alu_result_stage
   import alu_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = CNT_W_DEF
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       opcode,
   input  logic [7:0]       arith_result,
   input  logic [7:0]       logic_result,
   input  logic [7:0]       mul_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       result,
   output logic             flag_zero,
   output logic             flag_carry,
   output logic             flag_err,
   output logic [CNT_W-1:0] op_count,
   output logic [CNT_W-1:0] err_count
);

   entry_t           push_entry_s;
   entry_t           head_s;
   logic             push_ready_s;
   logic             pop_valid_s;
   logic [7:0]       sel_s;
   logic             carry_s;
   logic             err_s;
   logic [CNT_W-1:0] op_count_r;
   logic [CNT_W-1:0] err_count_r;

   // carry is bit 4 of the add/sub result; illegal opcodes force a zero result
   always_comb begin
      sel_s   = 8'h00;
      carry_s = 1'b0;
      err_s   = 1'b0;
      case (opcode)
         OP_ADD, OP_SUB: begin
            sel_s   = arith_result;
            carry_s = arith_result[4];
         end
         OP_LOGIC: sel_s = logic_result;
         OP_MUL:   sel_s = mul_result;
         default: begin
            sel_s = 8'h00;
            err_s = 1'b1;
         end
      endcase
      push_entry_s = make_entry(sel_s, carry_s, err_s);
   end

   alu_skid_fifo2 #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_valid (in_valid),
      .push_ready (push_ready_s),
      .push_data  (push_entry_s),
      .pop_valid  (pop_valid_s),
      .pop_ready  (out_ready),
      .pop_data   (head_s)
   );

   // debug counters
   always_ff @(posedge clk) begin
      if (rst) begin
         op_count_r  <= {CNT_W{1'b0}};
         err_count_r <= {CNT_W{1'b0}};
      end else begin
         if (pop_valid_s && out_ready) begin
            op_count_r <= op_count_r + CNT_W'(1);
         end
         if (in_valid && push_ready_s && err_s && (err_count_r != {CNT_W{1'b1}})) begin
            err_count_r <= err_count_r + CNT_W'(1);
         end
      end
   end

   assign in_ready   = push_ready_s;
   assign out_valid  = pop_valid_s;
   assign result     = head_s.res;
   assign flag_zero  = head_s.zero;
   assign flag_carry = head_s.carry;
   assign flag_err   = head_s.err;
   assign op_count   = op_count_r;
   assign err_count  = err_count_r;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage with a queue scoreboard that tracks
// the expected buffer contents, handshakes and counters cycle by cycle.
module tb_alu_result_stage;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] opcode;
   logic [7:0] arith_result;
   logic [7:0] logic_result;
   logic [7:0] mul_result;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] result;
   logic       flag_zero;
   logic       flag_carry;
   logic       flag_err;
   logic [7:0] op_count;
   logic [7:0] err_count;

   int checks = 0;
   int errors = 0;

   logic [10:0] q[$];
   logic [7:0]  m_op;
   logic [7:0]  m_err;
   logic        armed = 1'b0;

   alu_result_stage #(.DEPTH(2), .CNT_W(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .opcode       (opcode),
      .arith_result (arith_result),
      .logic_result (logic_result),
      .mul_result   (mul_result),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .result       (result),
      .flag_zero    (flag_zero),
      .flag_carry   (flag_carry),
      .flag_err     (flag_err),
      .op_count     (op_count),
      .err_count    (err_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [10:0] model(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] l, input logic [7:0] m);
      logic [7:0] r;
      case (op)
         3'b000, 3'b001: r = a;
         3'b010:         r = l;
         3'b011:         r = m;
         default:        r = 8'h00;
      endcase
      return {r, (r == 8'h00), ((op == 3'b000 || op == 3'b001) ? r[4] : 1'b0), op[2]};
   endfunction

   // scoreboard: compare against the model, then apply this cycle's handshakes
   always @(negedge clk) begin
      logic [10:0] head_exp;
      if (armed) begin
         head_exp = (q.size() != 0) ? q[0] : 11'h000;
         chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
         chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
         chk("head_entry", {21'd0, result, flag_zero, flag_carry, flag_err}, {21'd0, head_exp});
         chk("op_count", {24'd0, op_count}, {24'd0, m_op});
         chk("err_count", {24'd0, err_count}, {24'd0, m_err});
      end
      if (rst) begin
         q.delete();
         m_op  = 8'h00;
         m_err = 8'h00;
         armed = 1'b1;
      end else if (armed) begin
         logic can_push;
         can_push = (q.size() < 2);
         if (out_ready && q.size() != 0) begin
            void'(q.pop_front());
            m_op = m_op + 8'd1;
         end
         if (in_valid && can_push) begin
            q.push_back(model(opcode, arith_result, logic_result, mul_result));
            if (opcode[2] && m_err != 8'hFF) m_err = m_err + 8'd1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] l, input logic [7:0] m);
      logic acc;
      acc          = 1'b0;
      opcode       = op;
      arith_result = a;
      logic_result = l;
      mul_result   = m;
      in_valid     = 1'b1;
      for (int i = 0; i < 20 && !acc; i++) begin
         acc = in_ready;
         step();
      end
      in_valid = 1'b0;
      chk("offer_accepted", {31'd0, acc}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      opcode = 3'b000; arith_result = 8'h00; logic_result = 8'h00; mul_result = 8'h00;
      step();
      step();
      rst = 1'b0;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_result", {24'd0, result}, 32'h0);
      chk("rst_counts", {16'd0, op_count, err_count}, 32'h0);

      // 1: single add, delivered next cycle with carry from bit 4
      out_ready = 1'b1;
      offer(3'b000, 8'h12, 8'h00, 8'h00);
      chk("t1_valid", {31'd0, out_valid}, 32'd1);
      chk("t1_result", {24'd0, result}, 32'h12);
      chk("t1_carry", {31'd0, flag_carry}, 32'd1);
      chk("t1_zero", {31'd0, flag_zero}, 32'd0);
      step();
      chk("t1_op_count", {24'd0, op_count}, 32'd1);

      // 2: fill with consumer stalled, hold a third offer, then release
      out_ready = 1'b0;
      offer(3'b010, 8'hAA, 8'h06, 8'hBB);
      offer(3'b011, 8'hAA, 8'h00, 8'h0F);
      chk("t2_full", {31'd0, in_ready}, 32'd0);
      opcode = 3'b000; arith_result = 8'h33; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t2_held_ready", {31'd0, in_ready}, 32'd0);
         chk("t2_head_stable", {24'd0, result}, 32'h06);
      end
      out_ready = 1'b1;
      offer(3'b000, 8'h33, 8'h00, 8'h00);
      step(); step(); step();
      chk("t2_drained", {31'd0, out_valid}, 32'd0);

      // 3: illegal opcode flags, then saturate the error counter
      out_ready = 1'b0;
      offer(3'b101, 8'h55, 8'h66, 8'h77);
      chk("t3_result", {24'd0, result}, 32'h00);
      chk("t3_err", {31'd0, flag_err}, 32'd1);
      chk("t3_zero", {31'd0, flag_zero}, 32'd1);
      chk("t3_err_count", {24'd0, err_count}, 32'd1);
      out_ready = 1'b1;
      for (int i = 0; i < 256; i++) begin
         offer(3'b100 + 3'(i % 4), 8'($urandom), 8'($urandom), 8'($urandom));
      end
      step(); step();
      chk("t3_err_sat", {24'd0, err_count}, 32'hFF);

      // 4: steady push+pop at count==1
      out_ready = 1'b0;
      offer(3'b011, 8'h00, 8'h00, 8'h21);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         opcode = 3'(i % 4); arith_result = 8'($urandom);
         logic_result = 8'($urandom); mul_result = 8'($urandom);
         step();
         chk("t4_stream_valid", {31'd0, out_valid}, 32'd1);
      end
      in_valid = 1'b0;
      step(); step();
      chk("t4_drained", {31'd0, out_valid}, 32'd0);

      // 5: reset with two entries buffered
      out_ready = 1'b0;
      offer(3'b000, 8'h41, 8'h00, 8'h00);
      offer(3'b010, 8'h00, 8'h42, 8'h00);
      chk("t5_full", {31'd0, in_ready}, 32'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t5_out_valid", {31'd0, out_valid}, 32'd0);
      chk("t5_in_ready", {31'd0, in_ready}, 32'd1);
      chk("t5_result", {24'd0, result}, 32'h00);
      chk("t5_counts", {16'd0, op_count, err_count}, 32'h0);
      out_ready = 1'b1;
      step(); step(); step();

      // 6: 256 deliveries wrap the op counter
      for (int i = 0; i < 256; i++) begin
         offer(3'(i % 4), 8'($urandom), 8'($urandom), 8'($urandom));
      end
      step(); step();
      chk("t6_op_wrap", {24'd0, op_count}, 32'h00);
      chk("t6_empty", {31'd0, out_valid}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
